attex_bus_ctrl: RTL and testbench

// CPU-side bus controller for the CD-i MONO1 board. Decodes SCC68070 cycles into chip

---
 rtl/attex_bus_ctrl_if.sv | 29 ++
 rtl/attex_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_attex_bus_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/attex_bus_ctrl_if.sv
// CPU-side bus bundle for the CD-i MONO1 bus controller.
// The master (CPU / bench) drives the address, strobes and direction.
// The slave (attex_bus_ctrl) returns the registered read data, the cycle-complete
// pulse and the bus error.
//
// Handshake: a cycle is open while as && (uds || lds). The controller answers with
// exactly one bus_ack pulse, or with bus_err held until as drops. The master keeps
// addr/strobes stable until it sees one of them, then drops as. No new cycle starts
// until the controller is back in IDLE.
interface attex_bus_ctrl_if;
  logic [23:1] addr;
  logic        as;
  logic        uds;
  logic        lds;
  logic        write_strobe;
  logic [15:0] data_in;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output addr, as, uds, lds, write_strobe,
    input  data_in, bus_ack, bus_err
  );

  modport slave (
    input  addr, as, uds, lds, write_strobe,
    output data_in, bus_ack, bus_err
  );
endinterface

// File: rtl/attex_bus_ctrl.sv
// attex_bus_ctrl: SCC68070 bus controller for the CD-i MONO1 board.
// Decodes CPU cycles into one-hot chip selects, sequences per-device wait states,
// returns bus_ack / bus_err / registered read data, runs the 68HC05 DTACK
// handshake, the delayed slave IRQ pulse and the NVRAM byte-write pulse.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   bus             CPU bus (addr, as, uds, lds, write_strobe -> data_in, bus_ack, bus_err)
//   mcd212_dout/ack MCD212 (and ROM) read data and cycle-complete
//   cdic_dout       CDIC read data
//   nvram_dout      NVRAM byte at nvram_addr
//   slave_data      68HC05 port A
//   dtackslaven     68HC05 DTACK, active-low
//   cs_*            one-hot chip selects, held from WAIT through DONE
//   nvram_addr      latched word address addr[13:1]
//   nvram_we        one-cycle NVRAM write pulse (coincides with bus_ack)
//   slave_irq       one-cycle IRQ pulse to the 68HC05
//   dbg_state       current FSM state
module attex_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CDIC_WAIT      = 1,
  parameter int NVRAM_WAIT     = 0,
  parameter int IRQ_DELAY      = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  attex_bus_ctrl_if.slave         bus,
  input  logic [15:0]             mcd212_dout,
  input  logic                    mcd212_ack,
  input  logic [15:0]             cdic_dout,
  input  logic [7:0]              nvram_dout,
  input  logic [7:0]              slave_data,
  input  logic                    dtackslaven,
  output logic                    cs_mcd212,
  output logic                    cs_cdic,
  output logic                    cs_slave,
  output logic                    cs_nvram,
  output logic [12:0]             nvram_addr,
  output logic                    nvram_we,
  output logic                    slave_irq,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {R_MCD, R_CDIC, R_SLAVE, R_NVRAM, R_ERR} region_t;

  localparam logic [7:0] TIMEOUT_W = TIMEOUT_CYCLES[7:0];
  localparam logic [7:0] CDIC_W    = CDIC_WAIT[7:0];
  localparam logic [7:0] NVRAM_W   = NVRAM_WAIT[7:0];
  localparam logic [7:0] IRQ_W     = IRQ_DELAY[7:0];

  state_t      state, next_state;
  region_t     region_q, dec;
  logic        write_q, uds_q, dtack_q;
  logic [7:0]  wait_cnt, irq_cnt, hi;
  logic [12:0] addr_q;
  logic [15:0] data_q, rd_data;
  logic        strobe_valid, complete, in_cycle, start;

  assign strobe_valid = bus.as && (bus.uds || bus.lds);
  assign start        = (state == S_IDLE) && strobe_valid;

  // Address decode on byte address bits [23:16]; error ranges take priority.
  always_comb begin
    hi  = bus.addr[23:16];
    dec = R_ERR;
    if ((hi >= 8'h60 && hi <= 8'hCF) || hi >= 8'hF0) dec = R_ERR;
    else if (hi == 8'h30)                           dec = R_CDIC;
    else if (hi == 8'h31)                           dec = R_SLAVE;
    else if (hi == 8'h32)                           dec = R_NVRAM;
    else if (hi <= 8'h27 || (hi >= 8'h40 && hi <= 8'h5F)) dec = R_MCD;
  end

  // Device completion and read data for the latched region.
  always_comb begin
    complete = 1'b0;
    rd_data  = 16'h0000;
    case (region_q)
      R_MCD:   begin complete = mcd212_ack;             rd_data = mcd212_dout; end
      R_CDIC:  begin complete = (wait_cnt == CDIC_W);   rd_data = cdic_dout; end
      R_NVRAM: begin complete = (wait_cnt == NVRAM_W);  rd_data = {nvram_dout, nvram_dout}; end
      R_SLAVE: begin
        // Rising edge of DTACK (release after the low phase) ends the slave cycle.
        complete = dtackslaven && !dtack_q;
        rd_data  = (slave_data == 8'h01) ? 16'h0202 : {slave_data, slave_data};
      end
      default: begin complete = 1'b0; rd_data = 16'h0000; end
    endcase
  end

  // Next state and state-derived outputs.
  always_comb begin
    next_state  = state;
    bus.bus_ack = (state == S_ACK);
    bus.bus_err = (state == S_ERR);
    in_cycle    = (state == S_WAIT) || (state == S_ACK) || (state == S_DONE);
    cs_mcd212   = in_cycle && (region_q == R_MCD);
    cs_cdic     = in_cycle && (region_q == R_CDIC);
    cs_slave    = in_cycle && (region_q == R_SLAVE);
    cs_nvram    = in_cycle && (region_q == R_NVRAM);
    case (state)
      S_IDLE: if (strobe_valid) next_state = (dec == R_ERR) ? S_ERR : S_WAIT;
      S_WAIT: begin
        if (!bus.as)                     next_state = S_IDLE;
        else if (complete)               next_state = S_ACK;
        else if (wait_cnt == TIMEOUT_W)  next_state = S_ERR;
      end
      S_ACK:  next_state = S_DONE;
      S_DONE: if (!bus.as) next_state = S_IDLE;
      S_ERR:  if (!bus.as) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      region_q <= R_MCD;
      write_q  <= 1'b0;
      uds_q    <= 1'b0;
      addr_q   <= 13'h0000;
      wait_cnt <= 8'h00;
      irq_cnt  <= 8'h00;
      dtack_q  <= 1'b1;
      data_q   <= 16'h0000;
      nvram_we <= 1'b0;
    end else begin
      state    <= next_state;
      dtack_q  <= dtackslaven;
      nvram_we <= 1'b0;
      if (start) begin
        region_q <= dec;
        write_q  <= bus.write_strobe;
        uds_q    <= bus.uds;
        addr_q   <= bus.addr[13:1];
        wait_cnt <= 8'h00;
      end
      if (state == S_WAIT && bus.as) begin
        if (complete) begin
          if (!write_q) data_q <= rd_data;
          if (write_q && uds_q && region_q == R_NVRAM) nvram_we <= 1'b1;
        end else if (wait_cnt != 8'hFF) begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
      // IRQ countdown is independent of the FSM; a new slave cycle restarts it.
      if (start && dec == R_SLAVE) irq_cnt <= IRQ_W;
      else if (irq_cnt != 8'h00)   irq_cnt <= irq_cnt - 8'd1;
    end
  end

  assign bus.data_in = data_q;
  assign nvram_addr  = addr_q;
  assign slave_irq   = (irq_cnt == 8'h01);
  assign dbg_state   = state;

endmodule

// File: tb/tb_attex_bus_ctrl.sv
module tb_attex_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mcd212_dout, cdic_dout;
  logic        mcd212_ack, dtackslaven;
  logic [7:0]  nvram_dout, slave_data;
  logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram;
  logic [12:0] nvram_addr;
  logic        nvram_we, slave_irq;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_bad    = 0;
  int ack_seen = 0;
  int we_seen  = 0;
  int irq_seen = 0;

  attex_bus_ctrl_if bus ();

  attex_bus_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .mcd212_dout (mcd212_dout),
    .mcd212_ack  (mcd212_ack),
    .cdic_dout   (cdic_dout),
    .nvram_dout  (nvram_dout),
    .slave_data  (slave_data),
    .dtackslaven (dtackslaven),
    .cs_mcd212   (cs_mcd212),
    .cs_cdic     (cs_cdic),
    .cs_slave    (cs_slave),
    .cs_nvram    (cs_nvram),
    .nvram_addr  (nvram_addr),
    .nvram_we    (nvram_we),
    .slave_irq   (slave_irq),
    .dbg_state   (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.bus_ack) ack_seen++;
    if (nvram_we)    we_seen++;
    if (slave_irq)   irq_seen++;
  endtask

  task automatic start_cycle(input logic [23:0] a, input logic wr, input logic u, input logic l);
    logic [23:0] av;
    av = a;
    bus.addr         = av[23:1];
    bus.write_strobe = wr;
    bus.uds          = u;
    bus.lds          = l;
    bus.as           = 1'b1;
  endtask

  task automatic end_cycle();
    bus.as  = 1'b0;
    bus.uds = 1'b0;
    bus.lds = 1'b0;
  endtask

  logic [3:0] cs_vec;
  assign cs_vec = {cs_mcd212, cs_cdic, cs_slave, cs_nvram};

  initial begin
    reset = 1'b1;
    mcd212_dout = 16'h0; mcd212_ack = 1'b0; cdic_dout = 16'h0;
    nvram_dout = 8'h0; slave_data = 8'h0; dtackslaven = 1'b1;
    bus.addr = '0; bus.as = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0; bus.write_strobe = 1'b0;
    tick(); tick();
    check("rst_ack", bus.bus_ack, 0);
    check("rst_err", bus.bus_err, 0);
    check("rst_data", bus.data_in, 0);
    check("rst_cs", cs_vec, 0);
    check("rst_we", nvram_we, 0);
    check("rst_irq", slave_irq, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    tick();

    // CDIC read: ack three edges after the strobe
    cdic_dout = 16'hBEEF; ack_seen = 0;
    start_cycle(24'h300000, 1'b0, 1'b1, 1'b1);
    tick(); check("cdic_cs0", cs_vec, 4'b0100); check("cdic_ack0", bus.bus_ack, 0);
    tick(); check("cdic_cs1", cs_vec, 4'b0100); check("cdic_ack1", bus.bus_ack, 0);
    tick(); check("cdic_ack2", bus.bus_ack, 1); check("cdic_data", bus.data_in, 16'hBEEF);
    check("cdic_cs2", cs_vec, 4'b0100);
    end_cycle();
    tick(); check("cdic_done_ack", bus.bus_ack, 0); check("cdic_done_cs", cs_vec, 4'b0100);
    tick(); check("cdic_idle_cs", cs_vec, 0); check("cdic_idle_st", dbg_state, 0);
    check("cdic_ackcnt", ack_seen, 1);

    // NVRAM write, uds=1
    ack_seen = 0; we_seen = 0;
    start_cycle(24'h320010, 1'b1, 1'b1, 1'b0);
    tick(); check("nvw_addr", nvram_addr, 13'h0008); check("nvw_cs", cs_vec, 4'b0001);
    check("nvw_we0", nvram_we, 0);
    tick(); check("nvw_we1", nvram_we, 1); check("nvw_ack1", bus.bus_ack, 1);
    end_cycle();
    tick(); check("nvw_we2", nvram_we, 0);
    tick(); check("nvw_wecnt", we_seen, 1); check("nvw_ackcnt", ack_seen, 1);
    check("nvw_data", bus.data_in, 16'hBEEF); check("nvw_err", bus.bus_err, 0);

    // NVRAM read, lds only: byte mirrored on both lanes, ack two edges after strobe
    nvram_dout = 8'h5A;
    start_cycle(24'h320004, 1'b0, 1'b0, 1'b1);
    tick(); check("nvr_ack0", bus.bus_ack, 0);
    tick(); check("nvr_ack1", bus.bus_ack, 1); check("nvr_data", bus.data_in, 16'h5A5A);
    check("nvr_we", nvram_we, 0);
    end_cycle(); tick(); tick();

    // Slave read with DTACK low pulse, then IRQ countdown
    slave_data = 8'h01; dtackslaven = 1'b1; irq_seen = 0; ack_seen = 0;
    start_cycle(24'h310000, 1'b0, 1'b1, 1'b1);
    tick(); check("slv_cs", cs_vec, 4'b0010);        // edge 0
    tick(); dtackslaven = 1'b0;                      // edge 1
    tick();                                          // edge 2
    tick(); check("slv_ack3", bus.bus_ack, 0);       // edge 3
    dtackslaven = 1'b1;
    tick(); check("slv_ack4", bus.bus_ack, 1); check("slv_data", bus.data_in, 16'h0202);
    end_cycle();
    for (int k = 5; k <= 21; k++) begin
      tick();
      if (k == 18) check("slv_irq18", slave_irq, 0);
      if (k == 19) check("slv_irq19", slave_irq, 1);
      if (k == 20) check("slv_irq20", slave_irq, 0);
    end
    check("slv_irqcnt", irq_seen, 1);
    check("slv_ackcnt", ack_seen, 1);
    check("slv_idle", dbg_state, 0);

    // Error regions: 0x700000, 0x280000 (gap), 0xF00000
    ack_seen = 0;
    start_cycle(24'h700000, 1'b0, 1'b1, 1'b1);
    tick(); check("err7_err0", bus.bus_err, 1); check("err7_cs", cs_vec, 0);
    tick(); check("err7_err1", bus.bus_err, 1);
    end_cycle();
    tick(); check("err7_clr", bus.bus_err, 0); check("err7_st", dbg_state, 0);
    start_cycle(24'h280000, 1'b0, 1'b1, 1'b0);
    tick(); check("err28_err", bus.bus_err, 1);
    end_cycle(); tick();
    start_cycle(24'hF00000, 1'b0, 1'b0, 1'b1);
    tick(); check("errF0_err", bus.bus_err, 1);
    end_cycle(); tick();
    check("err_ackcnt", ack_seen, 0);
    check("err_data", bus.data_in, 16'h0202);

    // MCD212 read with ack; top of the first MCD212 window
    mcd212_dout = 16'h1234;
    start_cycle(24'h27FFFE, 1'b0, 1'b1, 1'b1);
    tick(); check("mcd_cs", cs_vec, 4'b1000); check("mcd_ack0", bus.bus_ack, 0);
    mcd212_ack = 1'b1;
    tick(); check("mcd_ack1", bus.bus_ack, 1); check("mcd_data", bus.data_in, 16'h1234);
    mcd212_ack = 1'b0; end_cycle(); tick(); tick();

    // MCD212 timeout
    ack_seen = 0;
    start_cycle(24'h400000, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 255; i++) tick();
    check("to_err255", bus.bus_err, 0); check("to_st255", dbg_state, 1);
    tick(); check("to_err256", bus.bus_err, 1); check("to_cs", cs_vec, 0);
    end_cycle();
    tick(); check("to_clr", bus.bus_err, 0); check("to_idle", dbg_state, 0);
    check("to_ackcnt", ack_seen, 0);

    // Slave abort, then reset mid-WAIT on a retry
    ack_seen = 0; dtackslaven = 1'b1;
    start_cycle(24'h310000, 1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    end_cycle();
    tick(); check("ab_idle", dbg_state, 0); check("ab_cs", cs_vec, 0);
    start_cycle(24'h310000, 1'b0, 1'b1, 1'b1);
    tick(); tick(); check("ab_retry_st", dbg_state, 1);
    reset = 1'b1;
    tick();
    check("ab_rst_st", dbg_state, 0); check("ab_rst_cs", cs_vec, 0);
    check("ab_rst_data", bus.data_in, 0); check("ab_rst_irq", slave_irq, 0);
    check("ab_rst_err", bus.bus_err, 0); check("ab_rst_addr", nvram_addr, 0);
    reset = 1'b0; end_cycle();
    tick();
    check("ab_ackcnt", ack_seen, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
